// File: rtl/debug_fmt.sv
// debug_fmt: formats a signed WIDTH-bit value as a fixed ASCII debug line
// "<LABEL><sign><d3><d2><d1><d0> \n" followed by NUL padding, then pulses
// send once the downstream transmitter is idle.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   format request (pulse or level), honoured only while ready
//   value  in   signed value, captured when start is accepted
//   busy   in   downstream transmitter busy
//   ready  out  high in IDLE only
//   send   out  one-cycle pulse: downstream latches msg
//   msg    out  message, byte 0 in the top byte
//
// state | meaning
// IDLE  | waiting for start, ready=1
// ABS   | split captured value into sign and magnitude, clear BCD/counter
// CONV  | double-dabble, one shift per cycle, WIDTH cycles
// WAIT  | hold until busy=0, then load msg
// SEND  | send=1 for one cycle
module debug_fmt #(
  parameter int          WIDTH   = 10,
  parameter int          MSG_LEN = 16,
  parameter logic [47:0] LABEL   = "Time: "
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  input  logic                 busy,
  output logic                 ready,
  output logic                 send,
  output logic [8*MSG_LEN-1:0] msg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int TOP   = 8*MSG_LEN - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    CONV = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [15:0]          bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [8*MSG_LEN-1:0] msg_q, msg_d;
  logic [15:0]          bcd_adj;

  // add-3 correction applied to every digit before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          value_d = value;
          state_d = ABS;
        end
      end
      ABS: begin
        neg_d = value_q[WIDTH-1];
        // unsigned result so the most negative value maps cleanly to 2^(WIDTH-1)
        mag_d = value_q[WIDTH-1] ? (~value_q + 1'b1) : value_q;
        bcd_d = '0;
        cnt_d = '0;
        state_d = CONV;
      end
      CONV: begin
        bcd_d = {bcd_adj[14:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (!busy) begin
          msg_d = '0;
          msg_d[TOP -: 48]      = LABEL;
          msg_d[TOP-48 -: 8]    = neg_q ? 8'h2D : 8'h20;
          msg_d[TOP-56 -: 8]    = {4'h3, bcd_q[15:12]};
          msg_d[TOP-64 -: 8]    = {4'h3, bcd_q[11:8]};
          msg_d[TOP-72 -: 8]    = {4'h3, bcd_q[7:4]};
          msg_d[TOP-80 -: 8]    = {4'h3, bcd_q[3:0]};
          msg_d[TOP-88 -: 8]    = 8'h20;
          msg_d[TOP-96 -: 8]    = 8'h0A;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      value_q <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign send  = (state_q == SEND);
  assign msg   = msg_q;

endmodule

// File: tb/tb_debug_fmt.sv
module tb_debug_fmt;

  localparam int WIDTH   = 10;
  localparam int MSG_LEN = 16;
  localparam int LAT     = WIDTH + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     value = '0;
  logic                 busy = 1'b0;
  logic                 ready;
  logic                 send;
  logic [8*MSG_LEN-1:0] msg;

  typedef struct {
    logic [8*MSG_LEN-1:0] msg;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_send = 1'b0;

  debug_fmt #(.WIDTH(WIDTH), .MSG_LEN(MSG_LEN), .LABEL("Time: ")) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .value(value),
    .busy (busy),
    .ready(ready),
    .send (send),
    .msg  (msg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every send pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && send) begin
      checks++;
      if (prev_send) begin
        errors++;
        $display("FAIL send_width: send high on consecutive cycles at cyc %0d", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send: got send at cyc %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (msg !== e.msg) begin
          errors++;
          $display("FAIL msg: got %h want %h", msg, e.msg);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency: send at cyc %0d want %0d", cyc, e.cyc);
        end
      end
    end
    prev_send <= rst ? send : 1'b0;
  end

  task automatic check(input string name, input logic [8*MSG_LEN-1:0] got,
                       input logic [8*MSG_LEN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got ready=0 want 1 after 300 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  // Issue one start pulse at a negedge where ready is already high.
  task automatic run(input logic [WIDTH-1:0] v, input logic [8*MSG_LEN-1:0] m);
    exp_t e;
    wait_ready();
    start = 1'b1;
    value = v;
    e.msg = m;
    e.cyc = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    value = '0;
  endtask

  initial begin
    exp_t e;
    int   c0;
    int   nsend;
    logic ok;

    #1;
    check("reset_ready", {127'b0, ready}, 128'd1);
    check("reset_send",  {127'b0, send},  128'd0);
    check("reset_msg",   msg, '0);
    @(negedge clk);
    rst = 1'b1;

    run(10'd123,  {"Time:  0123 \n", 24'h0});
    run(10'h385,  {"Time: -0123 \n", 24'h0});
    run(10'd1000, {"Time: -0024 \n", 24'h0});
    run(10'h200,  {"Time: -0512 \n", 24'h0});
    run(10'h1FF,  {"Time:  0511 \n", 24'h0});
    run(10'h000,  {"Time:  0000 \n", 24'h0});
    wait_drain();

    // busy held across WAIT entry
    wait_ready();
    busy  = 1'b1;
    start = 1'b1;
    value = 10'd7;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (send || msg !== {"Time:  0000 \n", 24'h0}) ok = 1'b0;
    end
    check("busy_hold", {127'b0, ok}, 128'd1);
    e.msg = {"Time:  0007 \n", 24'h0};
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    busy = 1'b0;
    wait_drain();

    // start during CONV is ignored
    run(10'd42, {"Time:  0042 \n", 24'h0});
    repeat (3) @(negedge clk);
    check("conv_ready", {127'b0, ready}, 128'd0);
    start = 1'b1;
    value = 10'd99;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    @(negedge clk);
    check("ready_after_send", {127'b0, ready}, 128'd1);

    // level start: second accept only one cycle after SEND returns to IDLE
    wait_ready();
    c0 = cyc;
    start = 1'b1;
    value = 10'd5;
    e.msg = {"Time:  0005 \n", 24'h0};
    e.cyc = c0 + 1 + LAT;
    exp_q.push_back(e);
    e.cyc = c0 + 1 + LAT + 2 + LAT;
    exp_q.push_back(e);
    repeat (14) @(negedge clk);
    check("level_idle_ready", {127'b0, ready}, 128'd1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // reset mid-CONV aborts the conversion
    wait_ready();
    start = 1'b1;
    value = 10'd321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", {127'b0, ready}, 128'd1);
    check("rst_send",  {127'b0, send},  128'd0);
    check("rst_msg",   msg, '0);
    @(negedge clk);
    rst = 1'b1;
    nsend = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (send) nsend++;
    end
    check("rst_no_send", 128'(nsend), 128'd0);

    // first start after reset is accepted immediately
    run(10'd9, {"Time:  0009 \n", 24'h0});
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_fmt.md
DEBUG_FMT -- requirements
Module: debug_fmt

Interface
REQ-001 Parameter WIDTH, default 10: width of signed two's-complement input value; legal range 2..14.
REQ-002 Parameter MSG_LEN, default 16: message length in bytes; legal range 13 and up.
REQ-003 Parameter LABEL, default "Time: ": 6-byte ASCII prefix placed at message bytes 0..5.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-low.
REQ-006 Port start  input  1: request to format value; one-cycle pulse or level.
REQ-007 Port value  input  WIDTH: signed number to format; sampled only when a start is accepted.
REQ-008 Port busy  input  1: downstream serial transmitter busy flag.
REQ-009 Port ready  output  1: high only in IDLE; a start is accepted only while ready is high.
REQ-010 Port send  output  1: one-cycle pulse telling the downstream transmitter to latch msg and transmit.
REQ-011 Port msg  output  8*MSG_LEN: formatted ASCII message; byte 0 (first transmitted) at msg[8*MSG_LEN-1 -: 8].

Function
REQ-012 FSM states SHALL be IDLE, ABS, CONV, WAIT and SEND.
REQ-013 IDLE: on start=1, value SHALL be captured and the FSM SHALL go to ABS; if start=0, the FSM stays in IDLE.
REQ-014 ABS (1 cycle): the sign bit SHALL be latched, the magnitude formed as a WIDTH-bit unsigned value (-2^(WIDTH-1) gives 2^(WIDTH-1) with no overflow), the BCD register and iteration counter cleared, then the FSM goes to CONV.
REQ-015 CONV: shift-add-3 (double-dabble) conversion into 4 BCD digits, one shift per cycle, exactly WIDTH cycles, then the FSM goes to WAIT.
REQ-016 Before each shift, every BCD digit >= 5 SHALL have 3 added to it.
REQ-017 WAIT: while busy=1, the FSM SHALL hold and msg SHALL be unchanged; on the first cycle with busy=0, msg SHALL be loaded and the FSM goes to SEND.
REQ-018 SEND: send=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-019 msg SHALL change only on the WAIT-to-SEND edge, never while the downstream is busy.
REQ-020 Message layout: bytes 0..5 LABEL; byte 6 '-' (0x2D) if negative, else ' ' (0x20).
REQ-021 Message layout, continued: bytes 7..10 zero-padded decimal digits, most significant first, each 0x30+digit; byte 11 ' '; byte 12 '\n' (0x0A); bytes 13..MSG_LEN-1 0x00.
REQ-022 Latency: a start accepted at edge E0 with busy=0 throughout SHALL produce send=1 from edge E0+WIDTH+2 to edge E0+WIDTH+3 (12 cycles for WIDTH=10).
REQ-023 start SHALL be ignored while ready=0; no queuing and no value capture.
REQ-024 A start sampled in the same cycle that SEND returns to IDLE SHALL be ignored; it is accepted on the next cycle if still high.
REQ-025 ready and send SHALL be decoded directly from FSM state registers, with no combinational path from start or busy.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, ready=1, send=0, msg all zeros, and BCD, counter and captured value to zero, regardless of the current state.
REQ-027 A reset asserted during ABS, CONV, WAIT or SEND SHALL abort the conversion; no send pulse follows deassertion.
REQ-028 After rst rises, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-029 WIDTH=10, value=10'd123, busy=0 -> send pulse 12 cycles after start, one cycle wide; msg = "Time:  0123 \n" followed by 3 bytes 0x00.
REQ-030 value=-10'd123 (10'h385) -> msg = "Time: -0123 \n"; value=10'd1000 (-24) -> "Time: -0024 \n".
REQ-031 Boundaries: value=10'h200 -> "Time: -0512 \n"; 10'h1FF -> "Time:  0511 \n"; 10'h000 -> "Time:  0000 \n".
REQ-032 busy held high for 500 cycles across the WAIT entry -> send stays 0 and msg is unchanged; busy falls -> msg updates and send pulses on the next edge.
REQ-033 start pulsed during CONV with a different value -> ignored; only the first value is emitted; ready returns to 1 after SEND.
REQ-034 rst=0 asserted mid-CONV -> ready=1, send=0 and msg=0 immediately; no send pulse within 50 cycles after release.
